// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle control FSM (fetch/decode/execute) for the ADD/SUB/AND/ADDI subset.
// Optional OVERFLOW_TRAP_EN: suppress overflowing writeback and enter a sticky TRAP state.
module control_unit_mc #(
    parameter int FETCH_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Of,
    input  logic       Zr,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       RB_w,
    output logic       AB_w,
    output logic [2:0] ULA_c,
    output logic       M_WREG,
    output logic       M_ULAA,
    output logic [1:0] M_ULAB,
    output logic       illegal_op,
    output logic       trap,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        RST     = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC_R  = 3'd3,
        EXEC_I  = 3'd4,
        ILLEGAL = 3'd5,
        TRAP    = 3'd6
    } state_t;

    localparam logic [3:0] LAST = 4'(FETCH_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       r_ok, i_ok, ovf, fetch_done, unused_ok;
    logic [2:0] ula_r;
    logic       pc_w_q, ir_w_q, rb_w_q, ab_w_q, m_wreg_q, m_ulaa_q, ill_q, trap_q;
    logic [2:0] ula_c_q;
    logic [1:0] m_ulab_q;

    assign r_ok       = OPCODE == 6'h00 && (FUNCT == 6'h20 || FUNCT == 6'h22 || FUNCT == 6'h24);
    assign i_ok       = OPCODE == 6'h08;
    assign ula_r      = FUNCT == 6'h22 ? 3'b010 : FUNCT == 6'h24 ? 3'b011 : 3'b001;
    assign fetch_done = cnt_q == LAST;
    assign unused_ok  = ^{Zr, Of};

`ifdef OVERFLOW_TRAP_EN
    // Overflow must block the write in the same cycle, so this gate stays combinational.
    assign ovf  = Of;
    assign RB_w = rb_w_q & ~Of;
`else
    assign ovf  = 1'b0;
    assign RB_w = rb_w_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = 4'd0;
        case (state_q)
            RST:            state_d = FETCH;
            FETCH: begin
                state_d = fetch_done ? DECODE : FETCH;
                cnt_d   = fetch_done ? 4'd0 : cnt_q + 4'd1;
            end
            DECODE:         state_d = r_ok ? EXEC_R : i_ok ? EXEC_I : ILLEGAL;
            EXEC_R, EXEC_I: state_d = ovf ? TRAP : FETCH;
            ILLEGAL:        state_d = FETCH;
            TRAP:           state_d = TRAP;
            default:        state_d = RST;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RST;
            cnt_q    <= 4'd0;
            pc_w_q   <= 1'b0;
            ir_w_q   <= 1'b0;
            rb_w_q   <= 1'b0;
            ab_w_q   <= 1'b0;
            ula_c_q  <= 3'b000;
            m_wreg_q <= 1'b0;
            m_ulaa_q <= 1'b0;
            m_ulab_q <= 2'b00;
            ill_q    <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_w_q   <= state_d == FETCH && cnt_d == LAST;
            ir_w_q   <= state_d == FETCH && cnt_d == LAST;
            rb_w_q   <= state_d == EXEC_R || state_d == EXEC_I;
            ab_w_q   <= state_d == DECODE;
            ula_c_q  <= (state_d == FETCH || state_d == EXEC_I) ? 3'b001 :
                        state_d == EXEC_R ? ula_r : 3'b000;
            m_wreg_q <= state_d == EXEC_R;
            m_ulaa_q <= state_d == EXEC_R || state_d == EXEC_I;
            m_ulab_q <= state_d == FETCH ? 2'b01 : state_d == EXEC_I ? 2'b10 : 2'b00;
            ill_q    <= state_d == ILLEGAL;
            trap_q   <= state_d == TRAP;
        end
    end

    assign PC_w       = pc_w_q;
    assign MEM_w      = 1'b0;
    assign IR_w       = ir_w_q;
    assign AB_w       = ab_w_q;
    assign ULA_c      = ula_c_q;
    assign M_WREG     = m_wreg_q;
    assign M_ULAA     = m_ulaa_q;
    assign M_ULAB     = m_ulab_q;
    assign illegal_op = ill_q;
    assign trap       = trap_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: randomized scoreboard bench; expected per-cycle control vectors are queued by the driver.
module tb_control_unit_mc;
    localparam int FW = 2;
`ifdef OVERFLOW_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic [5:0]  OPCODE = 6'h00, FUNCT = 6'h00;
    logic        Of = 1'b0, Zr = 1'b0;
    logic        PC_w, MEM_w, IR_w, RB_w, AB_w, M_WREG, M_ULAA, illegal_op, trap;
    logic [2:0]  ULA_c, state_dbg;
    logic [1:0]  M_ULAB;
    logic [16:0] got, e_m;
    string       nm_m;
    logic [16:0] exp_q[$];
    string       name_q[$];
    logic        mon_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    logic [5:0]  r_op, r_fn;
    logic        r_of;

    control_unit_mc #(.FETCH_WAIT(FW)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Zr(Zr),
        .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w), .AB_w(AB_w), .ULA_c(ULA_c),
        .M_WREG(M_WREG), .M_ULAA(M_ULAA), .M_ULAB(M_ULAB), .illegal_op(illegal_op),
        .trap(trap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign got = {PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_c, M_WREG, M_ULAA, M_ULAB, illegal_op, trap, state_dbg};

    function automatic logic [16:0] vec(input logic [2:0] st, input logic pcw, input logic irw,
                                        input logic rbw, input logic abw, input logic [2:0] ula,
                                        input logic wreg, input logic ulaa, input logic [1:0] ulab,
                                        input logic ill, input logic trp);
        return {pcw, 1'b0, irw, rbw, abw, ula, wreg, ulaa, ulab, ill, trp, st};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: got %h, nothing expected", got);
            end else begin
                e_m  = exp_q.pop_front();
                nm_m = name_q.pop_front();
                if (got !== e_m) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h (t=%0t)", nm_m, got, e_m, $time);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [16:0] e, input logic of, input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        Of    = of;
        exp_q.push_back(e);
        name_q.push_back(nm);
        mon_en = 1'b1;
    endtask

    task automatic fetch_cycles();
        for (int k = 0; k < FW; k++)
            cyc("fetch", vec(3'd1, k == FW - 1, k == FW - 1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0),
                rnd_bit(), 1'b0);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic of_x);
        logic       is_r, is_i, wr;
        logic [2:0] ula;
        OPCODE = op;
        FUNCT  = fn;
        is_r = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        is_i = op == 6'h08;
        ula  = fn == 6'h20 ? 3'b001 : fn == 6'h22 ? 3'b010 : 3'b011;
        wr   = !(TRAP_EN && of_x);
        fetch_cycles();
        cyc("decode", vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0), rnd_bit(), 1'b0);
        if (is_r)
            cyc("exec_r", vec(3'd3, 1'b0, 1'b0, wr, 1'b0, ula, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0), of_x, 1'b0);
        else if (is_i)
            cyc("exec_i", vec(3'd4, 1'b0, 1'b0, wr, 1'b0, 3'b001, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0), of_x, 1'b0);
        else
            cyc("illegal", vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0), rnd_bit(), 1'b0);
    endtask

    // An overflowing execute either traps (held until reset) or simply returns to fetch.
    task automatic ovf_case(input logic [5:0] op, input logic [5:0] fn);
        instr(op, fn, 1'b1);
        if (TRAP_EN) begin
            for (int k = 0; k < 3; k++)
                cyc("trap_hold", vec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1),
                    rnd_bit(), k == 2);
            cyc("trap_reset", 17'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        cyc("reset", 17'h0, 1'b0, 1'b1);
        cyc("reset", 17'h0, 1'b0, 1'b1);
        cyc("reset_rel", 17'h0, 1'b0, 1'b0);
        instr(6'h00, 6'h22, 1'b0);
        instr(6'h08, 6'h11, 1'b0);
        instr(6'h3F, 6'h20, 1'b0);
        instr(6'h00, 6'h25, 1'b0);
        instr(6'h00, 6'h20, 1'b0);
        instr(6'h00, 6'h24, 1'b0);
        OPCODE = 6'h08;
        cyc("mid_fetch", vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0), 1'b0, 1'b1);
        cyc("mid_rst", 17'h0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       r_op = 6'h00;
                1:       r_op = 6'h08;
                2:       r_op = 6'h3F;
                default: r_op = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 4))
                0:       r_fn = 6'h20;
                1:       r_fn = 6'h22;
                2:       r_fn = 6'h24;
                3:       r_fn = 6'h25;
                default: r_fn = 6'($urandom_range(0, 63));
            endcase
            r_of = TRAP_EN ? 1'b0 : rnd_bit();
            instr(r_op, r_fn, r_of);
        end
        ovf_case(6'h00, 6'h20);
        ovf_case(6'h08, 6'h05);
        instr(6'h00, 6'h22, 1'b0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
